// File: rtl/seven_seg_pkg.sv
// Shared constants, brightness type and hex decoder for the seven-segment scan driver.
// Segment bit order is {g,f,e,d,c,b,a}, logical polarity (1 = lit).
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] SEG_ALL = 7'h7F;

  localparam int BRIGHT_W_DEFAULT = 3;
  typedef logic [BRIGHT_W_DEFAULT-1:0] bright_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_refresh_timer.sv
// Slot timer: divides clk into REFRESH_DIV+1 cycle slots and steps the scanned digit index.
// slot_end/frame_end flag the cycle whose closing edge starts a new slot / new frame.
module seven_seg_refresh_timer #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 20000,
  parameter int CNT_W       = (REFRESH_DIV > 0) ? $clog2(REFRESH_DIV + 1) : 1,
  parameter int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] digit_idx,
  output logic             tick,
  output logic             frame_start,
  output logic             slot_end,
  output logic             frame_end
);

  logic [CNT_W-1:0] cnt;

  assign slot_end  = (cnt == CNT_W'(REFRESH_DIV));
  assign frame_end = slot_end && (digit_idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      digit_idx   <= '0;
      tick        <= 1'b0;
      frame_start <= 1'b0;
    end else if (slot_end) begin
      cnt         <= '0;
      tick        <= 1'b1;
      frame_start <= frame_end;
      digit_idx   <= frame_end ? '0 : digit_idx + 1'b1;
    end else begin
      cnt         <= cnt + 1'b1;
      tick        <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: rtl/seven_seg_scan_mux.sv
// Multiplexed N-digit seven-segment driver with double-buffered display data and PWM dimming.
// New data is committed only at frame boundaries so a frame never mixes old and new digits.
module seven_seg_scan_mux
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 20000,
  parameter int CNT_W          = (REFRESH_DIV > 0) ? $clog2(REFRESH_DIV + 1) : 1,
  parameter int IDX_W          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  parameter int BRIGHT_W       = 3,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic                    load_ack,
  output logic [6:0]              segment,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    tick,
  output logic                    frame_start
);

  logic                    slot_end;
  logic                    frame_end;

  logic [4*NUM_DIGITS-1:0] pend_digits, act_digits;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
  logic [NUM_DIGITS-1:0]   pend_blank, act_blank;
  logic                    pend_valid, act_valid;

  logic [BRIGHT_W-1:0]     bright_q;
  logic [BRIGHT_W-1:0]     pwm_cnt;

  logic [3:0]              cur_nib;
  logic [6:0]              seg_d, seg_q;
  logic                    dp_d, dp_q;
  logic [NUM_DIGITS-1:0]   an_d, an_q;

  seven_seg_refresh_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .CNT_W      (CNT_W),
    .IDX_W      (IDX_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .digit_idx  (digit_idx),
    .tick       (tick),
    .frame_start(frame_start),
    .slot_end   (slot_end),
    .frame_end  (frame_end)
  );

  // A load landing on the frame boundary bypasses pending and goes straight to active.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_blank  <= '0;
      pend_valid  <= 1'b0;
      act_digits  <= '0;
      act_dp      <= '0;
      act_blank   <= '0;
      act_valid   <= 1'b0;
      load_ack    <= 1'b0;
      bright_q    <= '0;
      pwm_cnt     <= '0;
    end else begin
      pwm_cnt  <= pwm_cnt + 1'b1;
      load_ack <= 1'b0;
      if (slot_end) begin
        bright_q <= brightness;
      end
      if (frame_end && load) begin
        act_digits <= digits_in;
        act_dp     <= dp_in;
        act_blank  <= blank_in;
        act_valid  <= 1'b1;
        pend_valid <= 1'b0;
        load_ack   <= 1'b1;
      end else if (frame_end && pend_valid) begin
        act_digits <= pend_digits;
        act_dp     <= pend_dp;
        act_blank  <= pend_blank;
        act_valid  <= 1'b1;
        pend_valid <= 1'b0;
        load_ack   <= 1'b1;
      end else if (load) begin
        pend_digits <= digits_in;
        pend_dp     <= dp_in;
        pend_blank  <= blank_in;
        pend_valid  <= 1'b1;
      end
    end
  end

  // Until the first transfer the active buffer holds no real data, so the display stays dark.
  always_comb begin
    seg_d   = SEG_OFF;
    dp_d    = 1'b0;
    an_d    = '0;
    cur_nib = act_digits[int'(digit_idx)*4 +: 4];
    if (act_valid && !act_blank[digit_idx]) begin
      seg_d = hex_to_seg(cur_nib);
      dp_d  = act_dp[digit_idx];
      if (pwm_cnt <= bright_q) begin
        an_d = NUM_DIGITS'(1) << digit_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_OFF;
      dp_q  <= 1'b0;
      an_q  <= '0;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign segment = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign dp      = dp_q ^ SEG_ACTIVE_LOW;
  assign anode   = an_q ^ {NUM_DIGITS{AN_ACTIVE_LOW}};

endmodule
